// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
//   Two-master / one-slave Wishbone arbiter. Master 0 is the core data port,
//   master 1 the instruction port. Data wins contention, but only for
//   MAX_DATA_BURST consecutive contested grants; after that the instruction
//   port is served. A watchdog aborts any strobe the slave leaves unacked
//   for TIMEOUT_CYCLES cycles (0 disables it).
//
// Ports
//   clk, rst                 clock, async active-high reset
//   m{0,1}_cyc/stb/we/sel/addr/data_i   master requests
//   m{0,1}_data_o, m{0,1}_ack_o         master responses
//   s_cyc/stb/we/sel/addr/data_o        slave request (owner pass-through)
//   s_data_i, s_ack_i                   slave response
//   grant_o                  one-hot owner (bit0 = m0, bit1 = m1), 00 idle
//   timeout_o                sticky watchdog-abort flag, cleared by rst only
module wb_master_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {IDLE, GRANT_D, GRANT_I, ABORT_D, ABORT_I} state_t;

  localparam int DW = (MAX_DATA_BURST > 0) ? $clog2(MAX_DATA_BURST + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX  = DW'(MAX_DATA_BURST);
  localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

  state_t          state, state_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic [TW-1:0]   tcnt;
  logic            timeout_q;
  logic            owner_d, owner_i, cur_cyc, wd_fire;

  assign owner_d   = (state == GRANT_D);
  assign owner_i   = (state == GRANT_I);
  assign cur_cyc   = owner_i ? m1_cyc_i : m0_cyc_i;
  // Ack in the same cycle as the last allowed strobe wins over the abort.
  assign wd_fire   = WD_EN && s_stb_o && !s_ack_i && (tcnt == TLAST);
  assign grant_o   = {owner_i | (state == ABORT_I), owner_d | (state == ABORT_D)};
  assign timeout_o = timeout_q;

  // Slave/master datapath: pure function of state so async reset drops the
  // slave cycle immediately.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_data_o = s_data_i;
    m1_data_o = s_data_i;
    case (state)
      GRANT_D: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        m0_ack_o = s_ack_i;
      end
      GRANT_I: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        m1_ack_o = s_ack_i;
      end
      ABORT_D: begin
        m0_ack_o  = 1'b1;
        m0_data_o = '0;
      end
      ABORT_I: begin
        m1_ack_o  = 1'b1;
        m1_data_o = '0;
      end
      default: ;
    endcase
  end

  // Next state and starvation counter.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || dcnt < DMAX)) begin
          state_nxt = GRANT_D;
          // Only contested data grants count toward the burst limit.
          if (m1_cyc_i && dcnt != DMAX) dcnt_nxt = dcnt + DW'(1);
        end else if (m1_cyc_i) begin
          state_nxt = GRANT_I;
          dcnt_nxt  = '0;
        end
      end
      GRANT_D, GRANT_I: begin
        if (!cur_cyc)     state_nxt = IDLE;
        else if (wd_fire) state_nxt = owner_d ? ABORT_D : ABORT_I;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dcnt      <= '0;
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      if (!(owner_d || owner_i) || s_ack_i || state_nxt != state) tcnt <= '0;
      else if (s_stb_o)                                           tcnt <= tcnt + TW'(1);
      if (state_nxt == ABORT_D || state_nxt == ABORT_I) timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter (MAX_DATA_BURST = 4, TIMEOUT_CYCLES = 8).
module tb_wb_master_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = 0;
  logic [31:0] m0_addr_i = 0, m0_data_i = 0, m0_data_o;
  logic        m0_ack_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = 0;
  logic [31:0] m1_addr_i = 0, m1_data_i = 0, m1_data_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [31:0] s_data_i = 0;
  logic        s_ack_i = 0;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  wb_master_arbiter #(.MAX_DATA_BURST(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_scyc",  {31'b0, s_cyc_o}, 0);
    chk("rst_grant", {30'b0, grant_o}, 0);
    chk("rst_tmo",   {31'b0, timeout_o}, 0);
    chk("rst_acks",  {30'b0, m1_ack_o, m0_ack_o}, 0);
    step(); step();
    rst = 1'b0;

    // Single data read at 0x100, ack two cycles after the grant
    m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'hF; m0_addr_i = 32'h100;
    step();
    chk("rd_grant", {30'b0, grant_o}, 32'h1);
    chk("rd_addr",  s_addr_o, 32'h100);
    chk("rd_sel",   {28'b0, s_sel_o}, 32'hF);
    chk("rd_noack", {31'b0, m0_ack_o}, 0);
    step();
    step();
    s_ack_i = 1; s_data_i = 32'hCAFEF00D;
    #1;
    chk("rd_ack",   {31'b0, m0_ack_o}, 1);
    chk("rd_data",  m0_data_o, 32'hCAFEF00D);
    chk("rd_m1ack", {31'b0, m1_ack_o}, 0);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("rd_ackpulse", {31'b0, m0_ack_o}, 0);
    step();
    chk("rd_idle", {30'b0, grant_o}, 0);

    // Contention: both request together, data first, idle gap, then instr
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 32'h200; m0_data_i = 32'h11112222;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h300;
    step();
    chk("ct_grant_d", {30'b0, grant_o}, 32'h1);
    chk("ct_addr_d",  s_addr_o, 32'h200);
    chk("ct_we",      {31'b0, s_we_o}, 1);
    chk("ct_wdata",   s_data_o, 32'h11112222);
    s_ack_i = 1;
    #1;
    chk("ct_ack_d",   {30'b0, m1_ack_o, m0_ack_o}, 32'h1);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    step();
    chk("ct_gap",      {30'b0, grant_o}, 0);
    chk("ct_gap_scyc", {31'b0, s_cyc_o}, 0);
    step();
    chk("ct_grant_i", {30'b0, grant_o}, 32'h2);
    chk("ct_addr_i",  s_addr_o, 32'h300);
    s_ack_i = 1;
    #1;
    chk("ct_ack_i",   {30'b0, m1_ack_o, m0_ack_o}, 32'h2);
    step();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();

    // Starvation bound: m1 waits while m0 issues back-to-back transfers
    m1_cyc_i = 1; m1_stb_i = 1;
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("sv_grant_d%0d", k), {30'b0, grant_o}, 32'h1);
      s_ack_i = 1;
      step();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      step();
      chk($sformatf("sv_idle%0d", k), {30'b0, grant_o}, 0);
      m0_cyc_i = 1; m0_stb_i = 1;
    end
    step();
    chk("sv_grant_i", {30'b0, grant_o}, 32'h2);
    chk("sv_dcnt0",   32'(dut.dcnt), 0);
    s_ack_i = 1;
    step();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();
    step();
    chk("sv_back_d", {30'b0, grant_o}, 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();

    // Ack exactly on the last allowed strobe cycle: normal completion
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h400;
    step();
    for (int k = 0; k < 7; k++) step();
    chk("bd_grant", {30'b0, grant_o}, 32'h1);
    s_ack_i = 1; s_data_i = 32'h0BADBEEF;
    #1;
    chk("bd_ack",  {31'b0, m0_ack_o}, 1);
    chk("bd_data", m0_data_o, 32'h0BADBEEF);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("bd_noabort", {31'b0, m0_ack_o}, 0);
    chk("bd_tmo",     {31'b0, timeout_o}, 0);
    step();

    // Watchdog: slave never acks m1, abort after 8 strobe cycles
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h500; s_data_i = 32'h12345678;
    step();
    for (int k = 0; k < 7; k++) step();
    chk("wd_pre_scyc", {31'b0, s_cyc_o}, 1);
    chk("wd_pre_tmo",  {31'b0, timeout_o}, 0);
    step();
    chk("wd_scyc",   {31'b0, s_cyc_o}, 0);
    chk("wd_sstb",   {31'b0, s_stb_o}, 0);
    chk("wd_m1ack",  {31'b0, m1_ack_o}, 1);
    chk("wd_m1data", m1_data_o, 0);
    chk("wd_m0ack",  {31'b0, m0_ack_o}, 0);
    chk("wd_m0data", m0_data_o, 32'h12345678);
    chk("wd_tmo",    {31'b0, timeout_o}, 1);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    chk("wd_idle",     {30'b0, grant_o}, 0);
    chk("wd_ackdone",  {31'b0, m1_ack_o}, 0);
    step();
    chk("wd_sticky",   {31'b0, timeout_o}, 1);

    // Reset mid-transfer: slave cycle drops without waiting for an edge
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h600;
    step();
    chk("mr_scyc_pre", {31'b0, s_cyc_o}, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_scyc",  {31'b0, s_cyc_o}, 0);
    chk("mr_grant", {30'b0, grant_o}, 0);
    chk("mr_ack",   {31'b0, m0_ack_o}, 0);
    chk("mr_tmo",   {31'b0, timeout_o}, 0);
    #2 rst = 1'b0;
    step();
    chk("mr_regrant", {30'b0, grant_o}, 32'h1);
    chk("mr_addr",    s_addr_o, 32'h600);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end
endmodule
